// File: rtl/seq_alu_mc.sv
// Multi-cycle ALU: shifts, add, sign-magnitude to two's complement, plus an iterative restoring divider.
// Latency: 1 cycle accept-to-DONE for single-cycle ops, M+1 for divide/remainder; o_ready low while busy.
module seq_alu_mc #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int CW = $clog2(M);

    localparam logic [N-1:0] OP_SHR = N'(0);
    localparam logic [N-1:0] OP_ADD = N'(1);
    localparam logic [N-1:0] OP_DIV = N'(2);
    localparam logic [N-1:0] OP_ZM  = N'(3);
    localparam logic [N-1:0] OP_REM = N'(4);
    localparam logic [N-1:0] OP_ASR = N'(5);

    localparam logic [M-1:0] M_W = M[M-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic [M-1:0]    quo_q, quo_d;
    logic [M-1:0]    rem_q, rem_d;
    logic [M-1:0]    div_b_q, div_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    result_q, result_d;
    logic [3:0]      status_q, status_d;

    logic [M:0]      add_sum;
    logic [M-1:0]    zm_neg;
    logic [M-1:0]    asr_res;
    logic [M-1:0]    fast_res;
    logic            fast_carry;
    logic            fast_err;
    logic            start_div;

    logic [M:0]      trial;
    logic [M:0]      diff;
    logic            step_ge;
    logic [M-1:0]    rem_nxt;
    logic [M-1:0]    quo_nxt;
    logic [M-1:0]    div_res;

    assign add_sum = {1'b0, i_arg_A} + {1'b0, i_arg_B};
    assign zm_neg  = -{1'b0, i_arg_A[M-2:0]};
    assign asr_res = $unsigned($signed(i_arg_A) >>> i_arg_B);

    assign start_div = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_arg_B != '0);

    always_comb begin
        fast_res   = '0;
        fast_carry = 1'b0;
        fast_err   = 1'b0;
        case (i_op)
            OP_SHR:  fast_res = (i_arg_B >= M_W) ? '0 : (i_arg_A >> i_arg_B);
            OP_ADD:  {fast_carry, fast_res} = add_sum;
            OP_ZM:   fast_res = i_arg_A[M-1] ? zm_neg : i_arg_A;
            OP_ASR:  fast_res = (i_arg_B >= M_W) ? {M{i_arg_A[M-1]}} : asr_res;
            // Divide/remainder only take this path when the divisor is zero.
            OP_DIV:  fast_err = 1'b1;
            OP_REM:  fast_err = 1'b1;
            default: fast_err = 1'b1;
        endcase
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign trial   = {rem_q, quo_q[M-1]};
    assign diff    = trial - {1'b0, div_b_q};
    assign step_ge = ~diff[M];
    assign rem_nxt = step_ge ? diff[M-1:0] : trial[M-1:0];
    assign quo_nxt = {quo_q[M-2:0], step_ge};
    assign div_res = is_rem_q ? rem_nxt : quo_nxt;

    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_b_d  = div_b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        status_d = status_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (start_div) begin
                        state_d  = S_DIV;
                        is_rem_d = (i_op == OP_REM);
                        quo_d    = i_arg_A;
                        div_b_d  = i_arg_B;
                        rem_d    = '0;
                        cnt_d    = CW'(M - 1);
                    end else begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        status_d = {fast_carry, ^fast_res, (fast_res == '0), fast_err};
                    end
                end
            end
            S_DIV: begin
                quo_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = div_res;
                    status_d = {1'b0, ^div_res, (div_res == '0), 1'b0};
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            is_rem_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_b_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_b_q  <= div_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign o_result = result_q;
    assign o_status = status_q;

endmodule

// File: tb/tb_seq_alu_mc.sv
// Bench for seq_alu_mc (M=8): arithmetic reference model with a per-cycle checker plus directed literal vectors.
module tb_seq_alu_mc;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_op;
    logic [7:0] i_arg_A;
    logic [7:0] i_arg_B;
    logic       o_valid;
    logic [7:0] o_result;
    logic [3:0] o_status;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    seq_alu_mc #(.M(8), .N(4)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_arg_A  (i_arg_A),
        .i_arg_B  (i_arg_B),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_status (o_status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] lat;
        logic [3:0] st;
        logic [7:0] res;
    } exp_t;

    // Reference: what each opcode must produce, straight from arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sum;
        logic carry, err;
        logic [7:0] r;
        carry = 1'b0; err = 1'b0; r = 8'h00;
        e.lat = 8'd1;
        case (op)
            4'd0: r = (b >= 8) ? 8'h00 : (a >> b);
            4'd1: begin sum = int'(a) + int'(b); r = sum[7:0]; carry = (sum > 255); end
            4'd2: if (b == 0) err = 1'b1; else begin r = a / b; e.lat = 8'd9; end
            4'd3: r = a[7] ? 8'((256 - int'(a & 8'h7F)) % 256) : a;
            4'd4: if (b == 0) err = 1'b1; else begin r = a % b; e.lat = 8'd9; end
            4'd5: r = (b >= 8) ? (a[7] ? 8'hFF : 8'h00) : ((a >> b) | (a[7] ? ~(8'hFF >> b) : 8'h00));
            default: err = 1'b1;
        endcase
        e.res = r;
        e.st  = {carry, ^r, (r == 8'h00), err};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: mk counts cycles since accept (0 = idle).
    int         mk = 0;
    int         mlat = 1;
    logic [7:0] pres = 8'h00, mres = 8'h00;
    logic [3:0] pst = 4'h0, mst = 4'h0;

    always @(posedge clk) begin
        exp_t e;
        e = model(i_op, i_arg_A, i_arg_B);
        if (i_reset) begin
            mk <= 0; mres <= 8'h00; mst <= 4'h0;
        end else if (mk == 0 && i_valid) begin
            mk <= 1; mlat <= int'(e.lat); pres <= e.res; pst <= e.st;
            if (e.lat == 8'd1) begin mres <= e.res; mst <= e.st; end
        end else if (mk != 0) begin
            if (mk >= mlat) mk <= 0;
            else begin
                mk <= mk + 1;
                if (mk + 1 == mlat) begin mres <= pres; mst <= pst; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(o_ready), 32'(mk == 0));
            chk("valid", 32'(o_valid), 32'(mk != 0 && mk == mlat));
            chk("result", 32'(o_result), 32'(mres));
            chk("status", 32'(o_status), 32'(mst));
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [3:0] es, input int el);
        int cyc;
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_arg_A = a; i_arg_B = b;
        @(negedge clk);
        // While busy, a held request with different operands must be ignored.
        i_valid = (el > 1); i_op = 4'd1; i_arg_A = 8'($urandom); i_arg_B = 8'($urandom);
        cyc = 1;
        while (!o_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 3) i_valid = 1'b0;
        end
        i_valid = 1'b0;
        chk({nm, "_lat"}, 32'(cyc), 32'(el));
        chk({nm, "_res"}, 32'(o_result), 32'(er));
        chk({nm, "_st"}, 32'(o_status), 32'(es));
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_op = 4'd0; i_arg_A = 8'h00; i_arg_B = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_status", 32'(o_status), 32'd0);
        chk_en = 1'b1;

        run_op("add_carry", 4'd1, 8'hF0, 8'h20, 8'h10, 4'b1100, 1);
        run_op("add_wrap0", 4'd1, 8'hFF, 8'h01, 8'h00, 4'b1010, 1);
        run_op("div_200_7", 4'd2, 8'd200, 8'd7, 8'd28, 4'b0100, 9);
        run_op("rem_200_7", 4'd4, 8'd200, 8'd7, 8'd4, 4'b0100, 9);
        run_op("div_255_1", 4'd2, 8'd255, 8'd1, 8'd255, 4'b0000, 9);
        run_op("div_small", 4'd2, 8'd7, 8'd200, 8'd0, 4'b0010, 9);
        run_op("rem_small", 4'd4, 8'd13, 8'd200, 8'd13, 4'b0100, 9);
        run_op("div_by0", 4'd2, 8'd5, 8'd0, 8'd0, 4'b0011, 1);
        run_op("rem_by0", 4'd4, 8'd9, 8'd0, 8'd0, 4'b0011, 1);
        run_op("bad_op_f", 4'hF, 8'h12, 8'h34, 8'd0, 4'b0011, 1);
        run_op("bad_op_6", 4'h6, 8'h12, 8'h34, 8'd0, 4'b0011, 1);
        run_op("zm_neg", 4'd3, 8'h85, 8'h00, 8'hFB, 4'b0100, 1);
        run_op("zm_negzero", 4'd3, 8'h80, 8'h00, 8'h00, 4'b0010, 1);
        run_op("zm_pos", 4'd3, 8'h05, 8'h00, 8'h05, 4'b0000, 1);
        run_op("zm_max", 4'd3, 8'hFF, 8'h00, 8'h81, 4'b0000, 1);
        run_op("shr_3", 4'd0, 8'hB4, 8'd3, 8'h16, 4'b0100, 1);
        run_op("shr_ovr", 4'd0, 8'hB4, 8'd8, 8'h00, 4'b0010, 1);
        run_op("asr_pos", 4'd5, 8'h70, 8'd2, 8'h1C, 4'b0100, 1);
        run_op("asr_ovr", 4'd5, 8'h90, 8'd9, 8'hFF, 4'b0000, 1);

        // Abort a division with reset four cycles after accept.
        @(negedge clk);
        i_valid = 1'b1; i_op = 4'd2; i_arg_A = 8'd255; i_arg_B = 8'd3;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_result", 32'(o_result), 32'd0);
        repeat (12) @(negedge clk);
        run_op("asr_neg", 4'd5, 8'h90, 8'd2, 8'hE4, 4'b0000, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
